// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its issue/writeback stage.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 8;
  localparam int AW     = 3;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_NOT     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_XNOR    = 4'b0100;
  localparam logic [3:0] ALU_NOR     = 4'b0101;
  localparam logic [3:0] ALU_ADD     = 4'b0110;
  localparam logic [3:0] ALU_SUB     = 4'b0111;
  localparam logic [3:0] ALU_ABSDIFF = 4'b1000;
  localparam logic [3:0] ALU_MUL     = 4'b1001;
  localparam logic [3:0] ALU_SLL     = 4'b1010;
  localparam logic [3:0] ALU_SLA     = 4'b1011;
  localparam logic [3:0] ALU_SRL     = 4'b1100;
  localparam logic [3:0] ALU_SRA     = 4'b1101;
  localparam logic [3:0] ALU_DEC     = 4'b1110;
  localparam logic [3:0] ALU_ARB     = 4'b1111;

endpackage

// File: rtl/alu.sv
// Combinational ALU: 16 operations selected by sel, Zero flags an all-zero result.
module alu #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        sel,
  input  logic              Cin,
  output logic [DATA_W-1:0] Y,
  output logic              Zero
);
  import alu_pkg::*;

  localparam int SW = $clog2(DATA_W);

  logic [SW-1:0] sh;
  assign sh = B[SW-1:0];

  always_comb begin
    Y = '0;
    case (sel)
      ALU_AND:     Y = A & B;
      ALU_OR:      Y = A | B;
      ALU_NOT:     Y = ~A;
      ALU_XOR:     Y = A ^ B;
      ALU_XNOR:    Y = ~(A ^ B);
      ALU_NOR:     Y = ~(A | B);
      ALU_ADD:     Y = A + B + DATA_W'(Cin);
      ALU_SUB:     Y = A - B;
      ALU_ABSDIFF: Y = (A >= B) ? (A - B) : (B - A);
      ALU_MUL:     Y = A * B;
      ALU_SLL:     Y = A << sh;
      ALU_SLA:     Y = A <<< sh;
      ALU_SRL:     Y = A >> sh;
      ALU_SRA:     Y = $signed(A) >>> sh;
      ALU_DEC:     Y[sh] = 1'b1;
      // Lowest set bit of B wins.
      ALU_ARB:     Y = B & (~B + DATA_W'(1));
      default:     Y = '0;
    endcase
  end

  assign Zero = (Y == '0);

endmodule

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: two async reads, one sync write, r0 hardwired to zero.
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mem <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around the combinational ALU: accept -> EX (ALU inputs) -> RES.
// No operand bypass; a RAW dependency on the EX destination stalls the command port.
module alu_issue_stage #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREG   = alu_pkg::NREG,
  parameter int AW     = alu_pkg::AW
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_sel,
  input  logic              cmd_cin,
  input  logic [AW-1:0]     cmd_rs1,
  input  logic [AW-1:0]     cmd_rs2,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [AW-1:0]     cmd_rd,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_sel,
  output logic              alu_Cin,
  input  logic [DATA_W-1:0] alu_Y,
  input  logic              alu_Zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic [AW-1:0]     res_rd
);
  import alu_pkg::*;

  logic              ex_valid;
  logic [AW-1:0]     ex_rd;
  logic              ex_adv;
  logic              hazard;
  logic              cmd_acc;
  logic              ld_acc;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  assign ex_adv = ex_valid & (~res_valid | res_ready);

  assign hazard = ex_valid & cmd_valid & (ex_rd != '0) &
                  ((cmd_rs1 == ex_rd) | (~cmd_imm_en & (cmd_rs2 == ex_rd)));

  assign ld_ready  = RST_N & ~ex_valid & ~res_valid;
  assign cmd_ready = RST_N & ~ld_en & (~ex_valid | ex_adv) & ~hazard;

  assign cmd_acc = cmd_valid & cmd_ready;
  assign ld_acc  = ld_en & ld_ready;

  // Preload needs EX empty and writeback needs EX full, so the two never collide.
  assign rf_we    = ld_acc | (ex_adv & (ex_rd != '0));
  assign rf_waddr = ex_adv ? ex_rd : ld_addr;
  assign rf_wdata = ex_adv ? alu_Y : ld_data;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_regfile (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (cmd_rs1),
    .rdata1 (rs1_data),
    .raddr2 (cmd_rs2),
    .rdata2 (rs2_data)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_sel   <= '0;
      alu_Cin   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_rd    <= '0;
    end else begin
      if (ex_adv) begin
        res_data  <= alu_Y;
        res_zero  <= alu_Zero;
        res_rd    <= ex_rd;
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end

      // alu_* only move on accept, so they stay stable while EX is held.
      if (cmd_acc) begin
        alu_A    <= rs1_data;
        alu_B    <= cmd_imm_en ? cmd_imm : rs2_data;
        alu_sel  <= cmd_sel;
        alu_Cin  <= cmd_cin;
        ex_rd    <= cmd_rd;
        ex_valid <= 1'b1;
      end else if (ex_adv) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
